// File: rtl/axil_timeout_guard.sv
// axil_timeout_guard: forwards AXI-Lite writes/reads to a slave and answers SLVERR upstream when the slave stalls too long.
module axil_timeout_guard #(
    parameter int          ADDR_W         = 40,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADDEAD
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    output logic              wr_hung,
    output logic              rd_hung,
    output logic [15:0]       timeout_count
);

    typedef enum logic [1:0] {IDLE, FWD, WAIT, RESP} state_t;

    localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      w_state, w_next, r_state, r_next;
    logic        w_accept, w_to, r_accept, r_to;
    logic        aw_pend, w_pend, ar_pend;
    logic [15:0] w_timer, r_timer;
    logic [1:0]  b_resp_q, r_resp_q;
    logic [31:0] r_data_q;
    logic [16:0] cnt_sum;

    assign m_axi_awvalid = aw_pend;
    assign m_axi_wvalid  = w_pend;
    assign m_axi_arvalid = ar_pend;
    assign m_axi_bready  = (w_state == WAIT) | wr_hung;
    assign m_axi_rready  = (r_state == WAIT) | rd_hung;
    assign s_axi_bvalid  = (w_state == RESP);
    assign s_axi_bresp   = b_resp_q;
    assign s_axi_rvalid  = (r_state == RESP);
    assign s_axi_rresp   = r_resp_q;
    assign s_axi_rdata   = r_data_q;
    assign cnt_sum       = {1'b0, timeout_count} + 17'(w_to) + 17'(r_to);

    // Write path next state: accept both channels together, forward, wait for B, respond; the timer bounds FWD+WAIT.
    always_comb begin
        w_next        = w_state;
        w_accept      = 1'b0;
        w_to          = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        case (w_state)
            IDLE: begin
                w_accept      = !axi_areset && s_axi_awvalid && s_axi_wvalid;
                s_axi_awready = w_accept;
                s_axi_wready  = w_accept;
                w_next        = w_accept ? (wr_hung ? RESP : FWD) : IDLE;
            end
            FWD: begin
                w_to   = (w_timer == T_LAST);
                w_next = w_to ? RESP :
                         ((!aw_pend || m_axi_awready) && (!w_pend || m_axi_wready)) ? WAIT : FWD;
            end
            WAIT: begin
                w_to   = (w_timer == T_LAST) && !m_axi_bvalid;
                w_next = (m_axi_bvalid || w_to) ? RESP : WAIT;
            end
            default: w_next = s_axi_bready ? IDLE : RESP;
        endcase
    end

    // Read path next state: same shape as the write path with a single address channel.
    always_comb begin
        r_next        = r_state;
        r_accept      = 1'b0;
        r_to          = 1'b0;
        s_axi_arready = 1'b0;
        case (r_state)
            IDLE: begin
                r_accept      = !axi_areset && s_axi_arvalid;
                s_axi_arready = r_accept;
                r_next        = r_accept ? (rd_hung ? RESP : FWD) : IDLE;
            end
            FWD: begin
                r_to   = (r_timer == T_LAST);
                r_next = r_to ? RESP : (!ar_pend || m_axi_arready) ? WAIT : FWD;
            end
            WAIT: begin
                r_to   = (r_timer == T_LAST) && !m_axi_rvalid;
                r_next = (m_axi_rvalid || r_to) ? RESP : WAIT;
            end
            default: r_next = s_axi_rready ? IDLE : RESP;
        endcase
    end

    // Write path registers; requests taken while hung are never forwarded so held m-side payload stays stable.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            w_state      <= IDLE;
            aw_pend      <= 1'b0;
            w_pend       <= 1'b0;
            w_timer      <= '0;
            b_resp_q     <= '0;
            wr_hung      <= 1'b0;
            m_axi_awaddr <= '0;
            m_axi_awprot <= '0;
            m_axi_wdata  <= '0;
            m_axi_wstrb  <= '0;
        end else begin
            w_state <= w_next;
            if (w_accept && !wr_hung) begin
                m_axi_awaddr <= s_axi_awaddr;
                m_axi_awprot <= s_axi_awprot;
                m_axi_wdata  <= s_axi_wdata;
                m_axi_wstrb  <= s_axi_wstrb;
            end
            aw_pend <= (w_accept && !wr_hung) || (aw_pend && !m_axi_awready);
            w_pend  <= (w_accept && !wr_hung) || (w_pend && !m_axi_wready);
            w_timer <= w_accept ? 16'd0 : (w_state == FWD || w_state == WAIT) ? w_timer + 16'd1 : w_timer;
            if ((w_accept && wr_hung) || w_to)
                b_resp_q <= 2'b10;
            else if (w_state == WAIT && m_axi_bvalid)
                b_resp_q <= m_axi_bresp;
            wr_hung <= w_to || (wr_hung && !m_axi_bvalid);
        end
    end

    // Read path registers; timeouts and hung requests return ERR_RDATA with SLVERR.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state      <= IDLE;
            ar_pend      <= 1'b0;
            r_timer      <= '0;
            r_resp_q     <= '0;
            r_data_q     <= '0;
            rd_hung      <= 1'b0;
            m_axi_araddr <= '0;
            m_axi_arprot <= '0;
        end else begin
            r_state <= r_next;
            if (r_accept && !rd_hung) begin
                m_axi_araddr <= s_axi_araddr;
                m_axi_arprot <= s_axi_arprot;
            end
            ar_pend <= (r_accept && !rd_hung) || (ar_pend && !m_axi_arready);
            r_timer <= r_accept ? 16'd0 : (r_state == FWD || r_state == WAIT) ? r_timer + 16'd1 : r_timer;
            if ((r_accept && rd_hung) || r_to) begin
                r_resp_q <= 2'b10;
                r_data_q <= ERR_RDATA;
            end else if (r_state == WAIT && m_axi_rvalid) begin
                r_resp_q <= m_axi_rresp;
                r_data_q <= m_axi_rdata;
            end
            rd_hung <= r_to || (rd_hung && !m_axi_rvalid);
        end
    end

    // Saturating timeout event counter, both paths may fire in the same cycle.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset)
            timeout_count <= '0;
        else if (w_to || r_to)
            timeout_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

endmodule

// File: doc/axil_timeout_guard.md
AXIL_TIMEOUT_GUARD -- requirements
Module: axil_timeout_guard

Sits between the PCIe-to-AXI bridge master port (s_axi_*) and the AXI-Lite register-file slave (m_axi_*). It forwards one transaction per direction and returns SLVERR upstream when the slave does not respond in time.

Interface
REQ-001 Parameter ADDR_W, default 40: address width on both sides.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, legal range 2..65535: cycles allowed for the slave to complete.
REQ-003 Parameter ERR_RDATA, default 32'hDEADDEAD: read data returned on a timeout or hung error.
REQ-004 axi_aclk  in  1: single clock; all logic is rising-edge.
REQ-005 axi_areset  in  1: reset, asynchronous, active-high.
REQ-006 s_axi_aw{valid,ready,addr,prot}  in/out/in/in  1/1/ADDR_W/3: upstream write address.
REQ-007 s_axi_w{valid,ready,data,strb}  in/out/in/in  1/1/32/4: upstream write data.
REQ-008 s_axi_b{valid,ready,resp}  out/in/out  1/1/2: upstream write response.
REQ-009 s_axi_ar{valid,ready,addr,prot}  in/out/in/in  1/1/ADDR_W/3: upstream read address.
REQ-010 s_axi_r{valid,ready,data,resp}  out/in/out/out  1/1/32/2: upstream read data.
REQ-011 m_axi_*: the mirror of REQ-006..010 toward the slave, with directions reversed.
REQ-012 wr_hung, rd_hung  out  1: a slave transaction is still outstanding after a timeout.
REQ-013 timeout_count  out  16: saturating count of timeout events.

Function
REQ-014 The write and read paths shall be independent FSMs, each with at most one outstanding transaction.
REQ-015 Write FSM states: IDLE, FWD, WAIT, RESP.
REQ-016 In write IDLE, s_axi_awready and s_axi_wready shall both be high combinationally only when s_axi_awvalid and s_axi_wvalid are both high.
REQ-017 On that accept, the FSM shall register addr/prot/data/strb.
- Not hung: go to FWD.
- Hung: go to RESP with resp 2'b10 and do not forward.
REQ-018 In write FWD, m_axi_awvalid and m_axi_wvalid shall assert the cycle after accept.
- Each deasserts independently after its own handshake.
- When both have completed, go to WAIT.
REQ-019 In write WAIT, m_axi_bready shall be 1. On m_axi_bvalid, capture m_axi_bresp and go to RESP.
REQ-020 In write RESP, s_axi_bvalid shall be 1 with the captured resp, held until s_axi_bready; then go to IDLE.
REQ-021 Read FSM states: IDLE, FWD, WAIT, RESP.
REQ-022 Read behaviour mirrors the write path:
- s_axi_arready is high in IDLE when s_axi_arvalid is high.
- m_axi_arvalid is held until m_axi_arready.
- m_axi_rready is 1 in WAIT; rdata/rresp are captured on m_axi_rvalid.
- s_axi_rvalid is held until s_axi_rready.
REQ-023 Each path shall have a 16-bit timer.
- Cleared on accept; increments every cycle in FWD and WAIT.
- Timeout fires when the timer equals TIMEOUT_CYCLES-1 and the completing handshake (bvalid/rvalid) is absent that cycle.
REQ-024 On timeout, the path shall go to RESP with resp 2'b10 (read data = ERR_RDATA) and set the hung flag.
REQ-025 While hung, m-side valids already asserted shall remain asserted until handshaken, for AXI compliance.
- The bready/rready drain shall stay high.
- The late response shall be discarded and the hung flag cleared on its handshake.
REQ-026 If the slave response and timeout expiry occur in the same cycle, the response shall win: no timeout, no count.
REQ-027 timeout_count shall increment by 1 per path timeout, by 2 if both paths time out in the same cycle, and saturate at 16'hFFFF.
REQ-028 Latency with a zero-wait slave: accept at cycle 0, m valid at cycle 1, s response valid at cycle 3.
REQ-029 An upstream request arriving while its path is in FWD/WAIT/RESP shall stall (ready low) with no loss.

Reset
REQ-030 While axi_areset is high:
- All FSMs go to IDLE.
- All valid/ready outputs are 0.
- Timers, timeout_count, wr_hung and rd_hung are 0.
- Captured data registers are 0.
REQ-031 Reset mid-transaction shall abandon the transaction; no response is issued after reset deasserts.

Verification
REQ-032 Write 0x12345678 to addr 0x8 with a zero-wait slave -> m_axi_awvalid at cycle 1, s_axi_bvalid at cycle 3 with resp 2'b00.
REQ-033 Read with a slave returning 0xDEADBEEF after 5 cycles -> s_axi_rdata=0xDEADBEEF, rresp=2'b00, timeout_count=0.
REQ-034 TIMEOUT_CYCLES=8, slave never asserts arready -> s_axi_rvalid after 8 FWD cycles, rdata=0xDEADDEAD, rresp=2'b10, rd_hung=1, count=1.
- A second read is answered SLVERR without m_axi_arvalid toggling.
- Slave arready then rvalid -> rd_hung=0.
REQ-035 Both paths time out in the same cycle with count=16'hFFFE -> count=16'hFFFF, no wrap.
REQ-036 bvalid arrives exactly at timer=TIMEOUT_CYCLES-1 -> normal resp, wr_hung=0, count unchanged.
REQ-037 axi_areset asserted in write WAIT -> all outputs 0 immediately; no s_axi_bvalid after release.
